// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Constants, state encoding and helper function shared by the
//               nibble-serial adder and its carry-select adder slice.
//               NIBBLE    - bits handled per cycle by the csa slice
//               state_t   - sequencer states IDLE / RUN / DONE
//               cnt_width - bit width of a counter over WIDTH/NIBBLE nibbles
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // clog2 of the nibble count, floored at 1 so the counter is never zero-width.
  function automatic int cnt_width(input int width);
    int nibs;
    nibs = width / NIBBLE;
    return (nibs <= 2) ? 1 : $clog2(nibs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa.sv
`default_nettype none
// ============================================================================
// Module      : csa
// Description : 4-bit carry-select adder. The low 2-bit half ripples. The
//               high half is precomputed for carry-in 0 and 1, and the low-half
//               carry selects between the two.
// Ports       : a, b  [3:0] in  - addends
//               cin         in  - carry in
//               s     [3:0] out - sum nibble
//               cout        out - carry out of bit 3
// Revision    : 1.0 - initial release
// ============================================================================
module csa
  import adder_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] s,
  output logic              cout
);

  logic [2:0] w_lo;
  logic [2:0] w_hi0;
  logic [2:0] w_hi1;
  logic [2:0] w_hi;

  always_comb begin
    w_lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    w_hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    w_hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    w_hi  = w_lo[2] ? w_hi1 : w_hi0;
    s     = {w_hi[1:0], w_lo[1:0]};
    cout  = w_hi[2];
  end

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Multi-cycle WIDTH-bit adder (a + b + cin). One nibble per
//               clock passes through a single csa instance, and the nibble
//               carry is registered between cycles. Valid/ready handshakes are
//               provided on both the operand side and the result side.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready   - operand handshake (ready only in IDLE)
//               a, b [WIDTH-1:0], cin - operands, sampled on the accept edge
//               out_valid/out_ready - result handshake (valid only in DONE)
//               sum [WIDTH-1:0], cout - last completed result
//               busy                - high in RUN or DONE
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int c_NIBS = WIDTH / NIBBLE;
  localparam int c_CW   = cnt_width(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NIBS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WIDTH-1:0]        r_a;
  logic [WIDTH-1:0]        r_b;
  logic                    r_carry;
  logic [WIDTH-NIBBLE-1:0] r_psum;
  logic [c_CW-1:0]         r_cnt;
  logic [WIDTH-1:0]        r_sum;
  logic                    r_cout;

  logic [NIBBLE-1:0]       w_s;
  logic                    w_co;
  logic [WIDTH-1:0]        w_psum_nxt;
  logic                    w_accept;
  logic                    w_last;

  csa u_csa (
    .a    (r_a[NIBBLE-1:0]),
    .b    (r_b[NIBBLE-1:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co)
  );

  // The partial sum holds only the upper WIDTH-NIBBLE bits. The nibble coming
  // out of csa enters at the top, so after the last nibble this concatenation
  // is the complete sum.
  assign w_psum_nxt = {w_s, r_psum};
  assign w_accept   = (r_state == IDLE) && in_valid;
  assign w_last     = (r_cnt == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_psum  <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> NIBBLE;
      r_b     <= r_b >> NIBBLE;
      r_carry <= w_co;
      r_psum  <= w_psum_nxt[WIDTH-1:NIBBLE];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_psum_nxt;
        r_cout <= w_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
`default_nettype wire
